pc_sequencer: RTL

//  Cycle-level sequencer for the program counter. Runs a two-phase machine cycle
//  (phi1/phi2) off sys_clock and issues one PC operation per cycle from a

---
 rtl/pc_sequencer_pkg.sv | 109 ++++++++++
 rtl/pc_sequencer_phase_generator.sv | 49 ++++
 rtl/pc_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and decode helpers for the program-counter sequencer.
// Holds the decoder opcodes, the FSM states, the per-cycle issue kinds
// and the strobe sets each issue kind produces.
package pc_sequencer_pkg;

    // Opcodes presented by the instruction decoder on cmd_op
    localparam logic [2:0] OP_HOLD      = 3'd0;
    localparam logic [2:0] OP_FETCH     = 3'd1;
    localparam logic [2:0] OP_JUMP      = 3'd2;
    localparam logic [2:0] OP_PAGE_JUMP = 3'd3;
    localparam logic [2:0] OP_PUSH      = 3'd4;

    // RUN accepts commands; PUSH_L owns the next cycle start for the low-byte push
    typedef enum logic {
        RUN    = 1'b0,
        PUSH_L = 1'b1
    } seq_state_e;

    // What the sequencer is doing during the current machine cycle
    typedef enum logic [2:0] {
        ISSUE_NONE      = 3'd0,
        ISSUE_HOLD      = 3'd1,
        ISSUE_FETCH     = 3'd2,
        ISSUE_JUMP      = 3'd3,
        ISSUE_PAGE_JUMP = 3'd4,
        ISSUE_PUSH_HI   = 3'd5,
        ISSUE_PUSH_LO   = 3'd6
    } issue_e;

    typedef struct packed {
        logic pcl_pcl;
        logic adl_pcl;
        logic pch_pch;
        logic adh_pch;
    } select_t;

    typedef struct packed {
        logic pcl_adl;
        logic pch_adh;
        logic pcl_db;
        logic pch_db;
    } drive_t;

    typedef struct packed {
        select_t sel;
        drive_t  drive;
        logic    inc;
        logic    busy;
    } strobe_set_t;

    // Translate the decoder port into an issue kind; idle or reserved codes hold the PC
    function automatic issue_e op_to_issue(input logic valid, input logic [2:0] op);
        issue_e kind;
        kind = ISSUE_HOLD;
        if (valid) begin
            case (op)
                OP_HOLD:      kind = ISSUE_HOLD;
                OP_FETCH:     kind = ISSUE_FETCH;
                OP_JUMP:      kind = ISSUE_JUMP;
                OP_PAGE_JUMP: kind = ISSUE_PAGE_JUMP;
                OP_PUSH:      kind = ISSUE_PUSH_HI;
                default:      kind = ISSUE_HOLD;
            endcase
        end
        return kind;
    endfunction

    // Strobe pattern for one machine cycle of the given issue kind
    function automatic strobe_set_t decode_issue(input issue_e kind);
        strobe_set_t s;
        s = '0;
        case (kind)
            ISSUE_HOLD: begin
                s.sel.pcl_pcl = 1'b1;
                s.sel.pch_pch = 1'b1;
            end
            ISSUE_FETCH: begin
                s.sel.pcl_pcl   = 1'b1;
                s.sel.pch_pch   = 1'b1;
                s.drive.pcl_adl = 1'b1;
                s.drive.pch_adh = 1'b1;
                s.inc           = 1'b1;
            end
            ISSUE_JUMP: begin
                s.sel.adl_pcl = 1'b1;
                s.sel.adh_pch = 1'b1;
            end
            ISSUE_PAGE_JUMP: begin
                s.sel.adl_pcl = 1'b1;
                s.sel.pch_pch = 1'b1;
            end
            ISSUE_PUSH_HI: begin
                s.sel.pcl_pcl  = 1'b1;
                s.sel.pch_pch  = 1'b1;
                s.drive.pch_db = 1'b1;
                s.busy         = 1'b1;
            end
            ISSUE_PUSH_LO: begin
                s.sel.pcl_pcl  = 1'b1;
                s.sel.pch_pch  = 1'b1;
                s.drive.pcl_db = 1'b1;
                s.busy         = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pc_sequencer_phase_generator.sv
// Two-phase machine-cycle timing: a counter that runs 0..2*CLK_DIV-1 and
// the phi1 level plus the phase start pulses decoded from it.
// The decoded phase outputs are held low while reset is asserted.
module phase_generator #(
    parameter int CLK_DIV = 4,
    parameter int CNT_W   = $clog2(2 * CLK_DIV)
) (
    input  logic             sys_clock,
    input  logic             reset,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next,
    output logic             phi1,
    output logic             phase_1_rising,
    output logic             phase_2_rising
);

    localparam logic [CNT_W-1:0] PHASE_2_START = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(2 * CLK_DIV - 1);

    // Next count value, wrapping at the end of the machine cycle
    always_comb begin
        cnt_next = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
            cnt_next = '0;
        end
    end

    // Phase counter register
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Phase level and start pulses decoded from the counter
    always_comb begin
        phi1           = 1'b0;
        phase_1_rising = 1'b0;
        phase_2_rising = 1'b0;
        if (!reset) begin
            phi1           = (cnt < PHASE_2_START);
            phase_1_rising = (cnt == '0);
            phase_2_rising = (cnt == PHASE_2_START);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: accepts one decoder command per machine cycle
// and turns it into registered PC select strobes, bus-drive strobes and the
// increment request. PUSH spans two machine cycles (high byte, then low byte).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       sys_clock,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_op,
    output logic       cmd_ready,
    output logic       busy,
    output logic       phase_1_rising,
    output logic       phase_2_rising,
    output logic       phi1,
    output logic       pcl_pcl,
    output logic       adl_pcl,
    output logic       pch_pch,
    output logic       adh_pch,
    output logic       pcl_adl,
    output logic       pch_adh,
    output logic       pcl_db,
    output logic       pch_db,
    output logic       increment_pc
);

    localparam int CNT_W = $clog2(2 * CLK_DIV);
    localparam logic [CNT_W-1:0] SEL_FIRST = CNT_W'(1);
    localparam logic [CNT_W-1:0] SEL_LAST  = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             cycle_start;
    logic             sel_window_next;

    seq_state_e  state_q;
    seq_state_e  state_d;
    issue_e      issue_q;
    issue_e      issue_d;
    strobe_set_t strobes_d;

    select_t sel_q;
    drive_t  drive_q;
    logic    inc_q;
    logic    busy_q;

    phase_generator #(
        .CLK_DIV (CLK_DIV),
        .CNT_W   (CNT_W)
    ) u_phase_generator (
        .sys_clock      (sys_clock),
        .reset          (reset),
        .cnt            (cnt),
        .cnt_next       (cnt_next),
        .phi1           (phi1),
        .phase_1_rising (phase_1_rising),
        .phase_2_rising (phase_2_rising)
    );

    assign cycle_start     = (cnt == '0);
    assign cmd_ready       = cycle_start && (state_q == RUN);
    assign sel_window_next = (cnt_next >= SEL_FIRST) && (cnt_next <= SEL_LAST);

    // Next state and next issue kind; both only move at the start of a machine cycle
    always_comb begin
        state_d   = state_q;
        issue_d   = issue_q;
        if (cycle_start) begin
            if (state_q == PUSH_L) begin
                issue_d = ISSUE_PUSH_LO;
                state_d = RUN;
            end else begin
                issue_d = op_to_issue(cmd_valid, cmd_op);
                if (issue_d == ISSUE_PUSH_HI) begin
                    state_d = PUSH_L;
                end
            end
        end
        strobes_d = decode_issue(issue_d);
    end

    // FSM, issue register and registered strobes; select strobes only inside the phi1 window
    always_ff @(posedge sys_clock) begin
        if (reset) begin
            state_q <= RUN;
            issue_q <= ISSUE_NONE;
            sel_q   <= '0;
            drive_q <= '0;
            inc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            sel_q   <= sel_window_next ? strobes_d.sel : '0;
            drive_q <= strobes_d.drive;
            inc_q   <= strobes_d.inc;
            busy_q  <= strobes_d.busy;
        end
    end

    assign pcl_pcl      = sel_q.pcl_pcl;
    assign adl_pcl      = sel_q.adl_pcl;
    assign pch_pch      = sel_q.pch_pch;
    assign adh_pch      = sel_q.adh_pch;
    assign pcl_adl      = drive_q.pcl_adl;
    assign pch_adh      = drive_q.pch_adh;
    assign pcl_db       = drive_q.pcl_db;
    assign pch_db       = drive_q.pch_db;
    assign increment_pc = inc_q;
    assign busy         = busy_q;

endmodule
